uart_tx_serializer: RTL

Serial transmit stage that pops bytes from the upstream `sync_fifo` read port with a valid/ready handshake and shifts them out as 8N1-style UART frames on a single TX line. It has one start bit (0), DATA_WIDTH data bits LSB first, and one stop bit (1), with a programmable bit period. It sits directly downstream of the transmit FIFO in the user project and drives the TX pad.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 53 +++++
 rtl/uart_tx_serializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the UART transmit serializer
//
// Contents:
//   UART_ST_*       2-bit frame state encodings
//   uart_state_e    enum built on those encodings
//   UART_DIV_WIDTH  default width of the bit-period divider
package uart_pkg;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    localparam int UART_DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_ST_IDLE,
        ST_START = UART_ST_START,
        ST_DATA  = UART_ST_DATA,
        ST_STOP  = UART_ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable bit-period counter with clear and end-of-period tick
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        restart the count at 0
//   load_i       latch period_i as the bit period (minus one)
//   en_i         count while a frame is in flight
//   period_i     bit period minus one, sampled on load_i
//   tick_o       combinational pulse in the last cycle of each bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] period_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;

    // Compare for equality against the latched period; the count never runs past it.
    assign tick_o = en_i && (cnt_q == period_q);

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load_i) begin
            period_d = period_i;
        end
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - pops bytes over valid/ready and sends start/data/stop UART frames
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ivalid       upstream byte valid
//   iready       registered ready; high only in IDLE
//   idata        byte to send, captured only on ivalid & iready
//   clk_div      bit period minus one, captured only on accept
//   tx           registered serial line, idle high
//   busy         registered, high from accept until the stop bit ends
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ivalid,
    output logic                  iready,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    output logic                  tx,
    output logic                  busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  iready_q, iready_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  tick;

    assign accept = (state_q == ST_IDLE) && ivalid && iready_q;

    uart_baud_cnt #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept),
        .load_i   (accept),
        .en_i     (state_q != ST_IDLE),
        .period_i (clk_div),
        .tick_o   (tick)
    );

    // Outputs are registered, so tx_d carries the level for the state being entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        iready_d  = iready_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                tx_d     = 1'b1;
                iready_d = 1'b1;
                busy_d   = 1'b0;
                if (accept) begin
                    shift_d   = idata;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    iready_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_d[0];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    tx_d     = 1'b1;
                    iready_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            iready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            iready_q  <= iready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx     = tx_q;
    assign iready = iready_q;
    assign busy   = busy_q;

endmodule
